// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared widths, FSM/owner enums and latched request type for the memory bus arbiter
package mem_bus_arbiter_pkg;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;
  localparam int SIZE_W = 3;
  localparam logic [SIZE_W-1:0] MSIZE_WORD = 3'd2;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;
  typedef struct packed {
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] wdata;
  } arb_req_t;
endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// arb_pick: combinational ibus/dbus chooser; ARB_ROUND_ROBIN_EN selects alternating grants on contention
module arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic       i_valid,
  input  logic       d_valid,
  input  arb_owner_t last_owner,
  output logic       grant,
  output arb_owner_t owner
);
  assign grant = i_valid | d_valid;
`ifdef ARB_ROUND_ROBIN_EN
  // on contention hand the port to whoever did not have it last
  always_comb owner = (i_valid & d_valid) ? ((last_owner == OWN_D) ? OWN_I : OWN_D) : (d_valid ? OWN_D : OWN_I);
`else
  logic unused_last;
  assign unused_last = last_owner;
  // dbus always wins so the memory stage is never starved
  always_comb owner = d_valid ? OWN_D : OWN_I;
`endif
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-beat memory port between ibus and dbus; ARB_ROUND_ROBIN_EN enables round-robin
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int STRB_W = DATA_W / 8,
  parameter int SIZE_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_data_ok,
  output logic [31:0]       i_data,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [SIZE_W-1:0] d_size,
  input  logic [STRB_W-1:0] d_strobe,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              c_valid,
  output logic              c_is_write,
  output logic [ADDR_W-1:0] c_addr,
  output logic [SIZE_W-1:0] c_size,
  output logic [STRB_W-1:0] c_strobe,
  output logic [DATA_W-1:0] c_wdata,
  input  logic              c_ready,
  input  logic [DATA_W-1:0] c_rdata
);
  arb_state_t  state_q, state_d;
  arb_owner_t  owner_q, owner_d, pick_owner, last_owner;
  arb_req_t    req_q, req_d;
  logic [31:0]       i_data_q, i_data_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant;

  arb_pick u_pick (
    .i_valid    (i_valid),
    .d_valid    (d_valid),
    .last_owner (last_owner),
    .grant      (grant),
    .owner      (pick_owner)
  );

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t last_q, last_d;
  assign last_owner = last_q;
  // remember the owner of every grant for the next contention
  always_comb last_d = (state_q == IDLE && grant) ? pick_owner : last_q;
  // last-owner register starts at ibus so the first contention goes to dbus
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_q <= OWN_I;
    else last_q <= last_d;
`else
  assign last_owner = OWN_I;
`endif

  // FSM next state, request latch at grant, read data capture on c_ready
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    req_d     = req_q;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = BUSY;
        owner_d = pick_owner;
        if (pick_owner == OWN_D) begin
          req_d.is_write = |d_strobe;
          req_d.addr     = d_addr;
          req_d.size     = d_size;
          req_d.strobe   = d_strobe;
          req_d.wdata    = d_wdata;
        end else begin
          req_d.is_write = 1'b0;
          req_d.addr     = i_addr;
          req_d.size     = MSIZE_WORD;
          req_d.strobe   = '0;
          req_d.wdata    = '0;
        end
      end
      BUSY: if (c_ready) begin
        state_d = RESP;
        if (owner_q == OWN_I) i_data_d = req_q.addr[2] ? c_rdata[63:32] : c_rdata[31:0];
        else d_rdata_d = c_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, owner, latch and response registers; reset abandons any in-flight transaction
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      req_q     <= '0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      req_q     <= req_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
    end

  assign c_valid    = state_q == BUSY;
  assign c_is_write = req_q.is_write;
  assign c_addr     = req_q.addr;
  assign c_size     = req_q.size;
  assign c_strobe   = req_q.strobe;
  assign c_wdata    = req_q.wdata;
  assign i_data_ok  = state_q == RESP && owner_q == OWN_I;
  assign d_data_ok  = state_q == RESP && owner_q == OWN_D;
  assign i_data     = i_data_q;
  assign d_rdata    = d_rdata_q;
endmodule
